// File: rtl/track_sensor_encoder.sv
// -----------------------------------------------------------------------------
// track_sensor_encoder
//
// Trackside front end for the train_signal controller. Two raw wheel/IR
// sensors, one on each approach side of a level crossing, are synchronised,
// debounced and edge-detected, then tracked by a small occupancy FSM. The FSM
// produces clean one-cycle entry/exit pulses for trains travelling in either
// direction and flags a sticky fault when the crossing stays occupied too long.
//
// Parameters
//   DEBOUNCE_CYCLES  consecutive stable cycles before a filtered level changes (>=1)
//   TIMEOUT_CYCLES   max cycles in an occupied state before FAULT (>=2)
//
// Ports
//   clk     in   system clock, all state on the rising edge
//   rst     in   asynchronous active-low reset (0 = reset)
//   sens_a  in   raw sensor on approach side A, asynchronous, active-high
//   sens_b  in   raw sensor on approach side B, asynchronous, active-high
//   entry   out  one-cycle pulse: a train has arrived at the crossing
//   exit    out  one-cycle pulse: the train has fully cleared the crossing
//   busy    out  high while the crossing is occupied
//   dir     out  direction of the current/last train: 0 = A->B, 1 = B->A
//   fault   out  sticky occupancy timeout, cleared only by rst
// -----------------------------------------------------------------------------
module track_sensor_encoder #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int TIMEOUT_CYCLES  = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic sens_a,
  input  logic sens_b,
  output logic entry,
  output logic exit,
  output logic busy,
  output logic dir,
  output logic fault
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [TW-1:0] TCNT_LAST = TW'(TIMEOUT_CYCLES - 1);

  // Channel 0 is sensor A, channel 1 is sensor B.
  logic [1:0] sens_vec;
  logic [1:0] rise;
  logic [1:0] fall;

  assign sens_vec = {sens_b, sens_a};

  // Per-sensor input path: 2-FF synchroniser, debounce counter, edge detect.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_chan
      logic          s1_reg;
      logic          s2_reg;
      logic          filt_reg;
      logic          filt_d_reg;
      logic [DW-1:0] cnt_reg;

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          s1_reg     <= 1'b0;
          s2_reg     <= 1'b0;
          filt_reg   <= 1'b0;
          filt_d_reg <= 1'b0;
          cnt_reg    <= '0;
        end else begin
          s1_reg     <= sens_vec[gi];
          s2_reg     <= s1_reg;
          filt_d_reg <= filt_reg;
          // Any cycle that agrees with the filtered level restarts the count,
          // so a glitch shorter than DEBOUNCE_CYCLES never reaches DB_LAST.
          if (s2_reg == filt_reg) begin
            cnt_reg <= '0;
          end else if (cnt_reg == DB_LAST) begin
            filt_reg <= s2_reg;
            cnt_reg  <= '0;
          end else begin
            cnt_reg <= cnt_reg + DW'(1);
          end
        end
      end

      assign rise[gi] = filt_reg & ~filt_d_reg;
      assign fall[gi] = ~filt_reg & filt_d_reg;
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    OCC_AB = 2'd1,
    OCC_BA = 2'd2,
    FAULT  = 2'd3
  } state_t;

  state_t        state_reg, state_next;
  logic          dir_reg, dir_next;
  logic          far_seen_reg, far_seen_next;
  logic [TW-1:0] tcnt_reg, tcnt_next;
  logic          entry_reg, entry_next;
  logic          exit_reg, exit_next;
  logic          busy_reg, busy_next;
  logic          fault_reg, fault_next;

  // In an occupied state dir_reg identifies the far sensor: B for A->B, A for B->A.
  logic far_rise;
  logic far_fall;

  assign far_rise = dir_reg ? rise[0] : rise[1];
  assign far_fall = dir_reg ? fall[0] : fall[1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= IDLE;
      dir_reg      <= 1'b0;
      far_seen_reg <= 1'b0;
      tcnt_reg     <= '0;
      entry_reg    <= 1'b0;
      exit_reg     <= 1'b0;
      busy_reg     <= 1'b0;
      fault_reg    <= 1'b0;
    end else begin
      state_reg    <= state_next;
      dir_reg      <= dir_next;
      far_seen_reg <= far_seen_next;
      tcnt_reg     <= tcnt_next;
      entry_reg    <= entry_next;
      exit_reg     <= exit_next;
      busy_reg     <= busy_next;
      fault_reg    <= fault_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    dir_next      = dir_reg;
    far_seen_next = far_seen_reg;
    tcnt_next     = tcnt_reg;
    entry_next    = 1'b0;
    exit_next     = 1'b0;

    case (state_reg)
      IDLE: begin
        // A wins a same-cycle tie. The B rise is then already the far
        // sensor being seen, so it arms the exit immediately.
        if (rise[0]) begin
          state_next    = OCC_AB;
          dir_next      = 1'b0;
          entry_next    = 1'b1;
          tcnt_next     = '0;
          far_seen_next = rise[1];
        end else if (rise[1]) begin
          state_next    = OCC_BA;
          dir_next      = 1'b1;
          entry_next    = 1'b1;
          tcnt_next     = '0;
          far_seen_next = 1'b0;
        end
      end

      OCC_AB, OCC_BA: begin
        // Near-sensor activity is ignored: long trains re-trigger it.
        if (far_rise) begin
          far_seen_next = 1'b1;
        end
        // Exit wins over a timeout landing in the same cycle.
        if (far_fall && far_seen_reg) begin
          state_next    = IDLE;
          exit_next     = 1'b1;
          far_seen_next = 1'b0;
        end else if (tcnt_reg == TCNT_LAST) begin
          state_next = FAULT;
        end else begin
          tcnt_next = tcnt_reg + TW'(1);
        end
      end

      FAULT: begin
        state_next = FAULT;
      end

      default: begin
        state_next = IDLE;
      end
    endcase

    busy_next  = (state_next == OCC_AB) || (state_next == OCC_BA);
    fault_next = (state_next == FAULT);
  end

  assign entry = entry_reg;
  assign exit  = exit_reg;
  assign busy  = busy_reg;
  assign dir   = dir_reg;
  assign fault = fault_reg;

endmodule

// File: tb/tb_track_sensor_encoder.sv
// -----------------------------------------------------------------------------
// tb_track_sensor_encoder
//
// Directed scenario tasks with fixed latency expectations, followed by a
// randomized run compared cycle-by-cycle against a behavioural model built
// from sample histories and occupancy bookkeeping.
// -----------------------------------------------------------------------------
module tb_track_sensor_encoder;

  localparam int D   = 4;
  localparam int T   = 64;
  localparam int LAT = D + 2;
  localparam bit [15:0] MASK = 16'((1 << D) - 1);

  logic clk    = 1'b0;
  logic rst    = 1'b1;
  logic sens_a = 1'b0;
  logic sens_b = 1'b0;
  logic entry, exit, busy, dir, fault;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  track_sensor_encoder #(
    .DEBOUNCE_CYCLES(D),
    .TIMEOUT_CYCLES (T)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .sens_a(sens_a),
    .sens_b(sens_b),
    .entry (entry),
    .exit  (exit),
    .busy  (busy),
    .dir   (dir),
    .fault (fault)
  );

  // ---------------------------------------------------------------------------
  // Behavioural reference model
  // A filtered level flips once the last D synchronised samples all disagree
  // with it. Occupancy is tracked as a record with the edge number of entry;
  // the timeout is plain edge arithmetic.
  // ---------------------------------------------------------------------------
  bit [1:0]  pipe_a, pipe_b;
  bit [15:0] hist_a, hist_b;
  int        n_seen;
  bit        mf_a, mfd_a, mf_b, mfd_b;
  bit        m_occ, m_dir, m_far, m_fault, m_entry, m_exit;
  int        m_cyc, m_tent;

  function automatic bit deb(input bit f, input bit [15:0] h, input int n);
    if (n >= D && (h & MASK) == (f ? 16'h0 : MASK)) return !f;
    return f;
  endfunction

  initial begin
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
        pipe_a = '0; pipe_b = '0; hist_a = '0; hist_b = '0; n_seen = 0;
        mf_a = 0; mfd_a = 0; mf_b = 0; mfd_b = 0;
        m_occ = 0; m_dir = 0; m_far = 0; m_fault = 0; m_entry = 0; m_exit = 0;
        m_cyc = 0; m_tent = 0;
      end else begin
        bit ra, fa, rb, fb, rfar, ffar, sa, sb;
        ra = mf_a & !mfd_a; fa = !mf_a & mfd_a;
        rb = mf_b & !mfd_b; fb = !mf_b & mfd_b;
        m_entry = 0; m_exit = 0;
        if (!m_fault) begin
          if (!m_occ) begin
            if (ra) begin
              m_occ = 1; m_dir = 0; m_far = rb; m_entry = 1; m_tent = m_cyc;
            end else if (rb) begin
              m_occ = 1; m_dir = 1; m_far = 0; m_entry = 1; m_tent = m_cyc;
            end
          end else begin
            rfar = m_dir ? ra : rb;
            ffar = m_dir ? fa : fb;
            if (ffar && m_far) begin
              m_occ = 0; m_exit = 1; m_far = 0;
            end else if (m_cyc - m_tent == T) begin
              m_fault = 1; m_occ = 0;
            end else if (rfar) begin
              m_far = 1;
            end
          end
        end
        sa = pipe_a[1]; pipe_a = {pipe_a[0], sens_a};
        sb = pipe_b[1]; pipe_b = {pipe_b[0], sens_b};
        hist_a = {hist_a[14:0], sa};
        hist_b = {hist_b[14:0], sb};
        if (n_seen < 1000) n_seen++;
        mfd_a = mf_a; mf_a = deb(mf_a, hist_a, n_seen);
        mfd_b = mf_b; mf_b = deb(mf_b, hist_b, n_seen);
        m_cyc++;
      end
    end
  end

  // Advance n clock cycles, leaving the bench just after a falling edge.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    #2 rst = 1'b0;
    #1;
    checks++; if (entry !== 1'b0) begin failures++; $display("FAIL reset_entry: got %0b want 0", entry); end
    checks++; if (exit  !== 1'b0) begin failures++; $display("FAIL reset_exit: got %0b want 0", exit); end
    checks++; if (busy  !== 1'b0) begin failures++; $display("FAIL reset_busy: got %0b want 0", busy); end
    checks++; if (dir   !== 1'b0) begin failures++; $display("FAIL reset_dir: got %0b want 0", dir); end
    checks++; if (fault !== 1'b0) begin failures++; $display("FAIL reset_fault: got %0b want 0", fault); end
    step(2);
    rst = 1'b1;
    step(8);
    checks++; if ({entry, busy, fault} !== 3'b000) begin failures++; $display("FAIL reset_idle: got %03b want 000", {entry, busy, fault}); end
    $display("test_reset done checks=%0d failures=%0d", checks, failures);
  endtask

  task automatic test_ab_pass();
    sens_a = 1'b1;
    step(LAT);
    checks++; if (entry !== 1'b0) begin failures++; $display("FAIL ab_entry_early: got %0b want 0", entry); end
    step(1);
    checks++; if (entry !== 1'b1) begin failures++; $display("FAIL ab_entry: got %0b want 1", entry); end
    checks++; if (dir   !== 1'b0) begin failures++; $display("FAIL ab_dir: got %0b want 0", dir); end
    checks++; if (busy  !== 1'b1) begin failures++; $display("FAIL ab_busy: got %0b want 1", busy); end
    step(1);
    checks++; if (entry !== 1'b0) begin failures++; $display("FAIL ab_entry_width: got %0b want 0", entry); end
    step(10 - (LAT + 2));
    sens_a = 1'b0; sens_b = 1'b1;
    step(10);
    sens_b = 1'b0;
    step(LAT);
    checks++; if ({exit, busy} !== 2'b01) begin failures++; $display("FAIL ab_exit_early: got exit,busy=%02b want 01", {exit, busy}); end
    step(1);
    checks++; if ({entry, exit, busy} !== 3'b010) begin failures++; $display("FAIL ab_exit: got entry,exit,busy=%03b want 010", {entry, exit, busy}); end
    step(1);
    checks++; if (exit !== 1'b0) begin failures++; $display("FAIL ab_exit_width: got %0b want 0", exit); end
    step(4);
    $display("test_ab_pass done checks=%0d failures=%0d", checks, failures);
  endtask

  task automatic test_ba_pass();
    sens_b = 1'b1;
    step(LAT + 1);
    checks++; if ({entry, busy, dir} !== 3'b111) begin failures++; $display("FAIL ba_entry: got entry,busy,dir=%03b want 111", {entry, busy, dir}); end
    step(10 - (LAT + 1));
    sens_b = 1'b0; sens_a = 1'b1;
    step(10);
    sens_a = 1'b0;
    step(LAT);
    checks++; if (exit !== 1'b0) begin failures++; $display("FAIL ba_exit_early: got %0b want 0", exit); end
    step(1);
    checks++; if ({exit, busy, dir, fault} !== 4'b1010) begin failures++; $display("FAIL ba_exit: got exit,busy,dir,fault=%04b want 1010", {exit, busy, dir, fault}); end
    step(4);
    $display("test_ba_pass done checks=%0d failures=%0d", checks, failures);
  endtask

  task automatic test_glitch();
    sens_a = 1'b1;
    step(D - 1);
    sens_a = 1'b0;
    for (int i = 0; i < 15; i++) begin
      step(1);
      checks++; if ({entry, busy} !== 2'b00) begin failures++; $display("FAIL glitch_c%0d: got entry,busy=%02b want 00", i, {entry, busy}); end
    end
    $display("test_glitch done checks=%0d failures=%0d", checks, failures);
  endtask

  task automatic test_simultaneous();
    sens_a = 1'b1; sens_b = 1'b1;
    step(LAT + 1);
    checks++; if ({entry, busy, dir} !== 3'b110) begin failures++; $display("FAIL simul_entry: got entry,busy,dir=%03b want 110", {entry, busy, dir}); end
    step(10 - (LAT + 1));
    sens_a = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step(1);
      checks++; if ({entry, exit, busy} !== 3'b001) begin failures++; $display("FAIL simul_hold_c%0d: got entry,exit,busy=%03b want 001", i, {entry, exit, busy}); end
    end
    sens_b = 1'b0;
    step(LAT);
    checks++; if (exit !== 1'b0) begin failures++; $display("FAIL simul_exit_early: got %0b want 0", exit); end
    step(1);
    checks++; if ({exit, busy} !== 2'b10) begin failures++; $display("FAIL simul_exit: got exit,busy=%02b want 10", {exit, busy}); end
    step(4);
    $display("test_simultaneous done checks=%0d failures=%0d", checks, failures);
  endtask

  task automatic test_timeout();
    sens_a = 1'b1;
    step(LAT + 1);
    checks++; if (entry !== 1'b1) begin failures++; $display("FAIL to_entry: got %0b want 1", entry); end
    step(T - 1);
    checks++; if ({fault, busy} !== 2'b01) begin failures++; $display("FAIL to_early: got fault,busy=%02b want 01", {fault, busy}); end
    step(1);
    checks++; if ({fault, busy} !== 2'b10) begin failures++; $display("FAIL to_fault: got fault,busy=%02b want 10", {fault, busy}); end
    for (int i = 0; i < 48; i++) begin
      if (i % 8 == 0) sens_b = ~sens_b;
      if (i == 20) sens_a = 1'b0;
      step(1);
      checks++; if ({entry, exit, busy, fault} !== 4'b0001) begin failures++; $display("FAIL to_sticky_c%0d: got entry,exit,busy,fault=%04b want 0001", i, {entry, exit, busy, fault}); end
    end
    sens_a = 1'b0; sens_b = 1'b0;
    $display("test_timeout done checks=%0d failures=%0d", checks, failures);
  endtask

  task automatic test_reset_mid();
    rst = 1'b0;
    step(2);
    rst = 1'b1;
    step(2);
    checks++; if (fault !== 1'b0) begin failures++; $display("FAIL rm_fault_clear: got %0b want 0", fault); end
    sens_b = 1'b1;
    step(LAT + 1);
    checks++; if ({entry, busy, dir} !== 3'b111) begin failures++; $display("FAIL rm_entry: got entry,busy,dir=%03b want 111", {entry, busy, dir}); end
    sens_a = 1'b1;
    step(3);
    rst = 1'b0;
    #1;
    checks++; if ({entry, exit, busy, dir, fault} !== 5'b00000) begin failures++; $display("FAIL rm_async: got entry,exit,busy,dir,fault=%05b want 00000", {entry, exit, busy, dir, fault}); end
    sens_b = 1'b0;
    @(negedge clk);
    step(1);
    rst = 1'b1;
    step(LAT);
    checks++; if (entry !== 1'b0) begin failures++; $display("FAIL rm_entry_early: got %0b want 0", entry); end
    step(1);
    checks++; if ({entry, busy, dir} !== 3'b110) begin failures++; $display("FAIL rm_fresh_entry: got entry,busy,dir=%03b want 110", {entry, busy, dir}); end
    sens_a = 1'b0;
    $display("test_reset_mid done checks=%0d failures=%0d", checks, failures);
  endtask

  task automatic test_random();
    int hold;
    logic [4:0] got, want;
    hold = 0;
    sens_a = 1'b0; sens_b = 1'b0;
    rst = 1'b0;
    step(2);
    rst = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      got  = {entry, exit, busy, dir, fault};
      want = {m_entry, m_exit, m_occ, m_dir, m_fault};
      checks++;
      if (got !== want) begin
        failures++;
        $display("FAIL random_c%0d: got %05b want %05b (entry,exit,busy,dir,fault)", i, got, want);
      end
      if (!rst) begin
        rst = 1'b1;
      end else if (hold == 0) begin
        if ($urandom_range(0, 99) < 4) begin
          rst = 1'b0;
        end else begin
          sens_a = 1'($urandom_range(0, 1));
          sens_b = 1'($urandom_range(0, 1));
          hold = ($urandom_range(0, 19) == 0) ? int'($urandom_range(60, 90))
                                              : int'($urandom_range(1, 12));
        end
      end else begin
        hold--;
      end
      step(1);
    end
    $display("test_random done checks=%0d failures=%0d", checks, failures);
  endtask

  initial begin
    test_reset();
    test_ab_pass();
    test_ba_pass();
    test_glitch();
    test_simultaneous();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
